// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time and
// queues the returned words, with their PCs, in a two-entry buffer for decode.
module fetch_unit (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus_4,
    input  logic        i_flush,
    output logic        o_pc_advance,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic [31:0] o_instr_pc_plus_4,
    input  logic        i_instr_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
    } entry_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_pc_plus_4;
    logic [1:0]  r_count;
    entry_t      r_head;
    entry_t      r_tail;

    logic        w_pop_req;
    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic        w_advance;
    logic [1:0]  w_count_after_pop;
    entry_t      w_new;
    logic        w_unused_pc_lsbs;

    // Addresses are word-aligned, so the low PC bits never reach the memory.
    assign w_unused_pc_lsbs = ^i_pc[1:0];

    // The issue decision looks at occupancy as if this cycle's pop already
    // happened; a flush blocks issue anyway, so it is not folded in here.
    assign w_pop_req         = (r_count != 2'd0) && i_instr_ready;
    assign w_count_after_pop = r_count - {1'b0, w_pop_req};
    assign w_pop             = w_pop_req && !i_flush;
    assign w_new             = '{instr: i_imem_rdata, pc: r_addr, pc_plus_4: r_pc_plus_4};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_push       = 1'b0;
        w_advance    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!i_flush && (w_count_after_pop < 2'd2)) begin
                    w_issue      = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (i_imem_ack) begin
                    w_state_next = S_IDLE;
                    if (!i_flush) begin
                        w_push    = 1'b1;
                        w_advance = 1'b1;
                    end
                end else if (i_flush) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The response to the flushed request is still owed; swallow it.
                if (i_imem_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request stays high through REQ and DRAIN; address only moves on issue.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_req       <= 1'b0;
            r_addr      <= 32'd0;
            r_pc_plus_4 <= 32'd0;
        end else begin
            r_req <= (w_state_next != S_IDLE);
            if (w_issue) begin
                r_addr      <= {i_pc[31:2], 2'b00};
                r_pc_plus_4 <= i_pc_plus_4;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: buffer storage is reset too, so the head outputs read zero out of reset rather than X.
        if (!i_reset_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= w_new;
                    end else begin
                        r_tail <= w_new;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= w_new;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= w_new;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_pc_advance      = w_advance;
    assign o_imem_req        = r_req;
    assign o_imem_addr       = r_addr;
    assign o_instr_valid     = (r_count != 2'd0);
    assign o_instr           = r_head.instr;
    assign o_instr_pc        = r_head.pc;
    assign o_instr_pc_plus_4 = r_head.pc_plus_4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small program counter and a
// variable-latency instruction memory surround the DUT.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        flush;
    logic [31:0] redirect;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus_4;
    logic        instr_ready;

    logic [31:0] pc_init;
    int          lat;
    int          wait_cnt;
    int          adv_cnt;
    logic        prev_req;
    int          n_checks;
    int          n_fail;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } acc_t;

    acc_t        q_acc[$];
    logic [31:0] q_issue[$];

    fetch_unit dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .i_pc              (pc),
        .i_pc_plus_4       (pc_plus_4),
        .i_flush           (flush),
        .o_pc_advance      (pc_advance),
        .o_imem_req        (imem_req),
        .o_imem_addr       (imem_addr),
        .i_imem_ack        (imem_ack),
        .i_imem_rdata      (imem_rdata),
        .o_instr_valid     (instr_valid),
        .o_instr           (instr),
        .o_instr_pc        (instr_pc),
        .o_instr_pc_plus_4 (instr_pc_plus_4),
        .i_instr_ready     (instr_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter: redirect on flush, otherwise step only on pc_advance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pc <= pc_init;
        else if (flush)      pc <= redirect;
        else if (pc_advance) pc <= pc + 32'd4;
    end
    assign pc_plus_4 = pc + 32'd4;

    // Memory acks once the request has been high for lat cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    wait_cnt <= 0;
        else if (!imem_req || imem_ack) wait_cnt <= 0;
        else                           wait_cnt <= wait_cnt + 1;
    end
    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = mem_word(imem_addr);

    // Mid-cycle monitor of issued addresses, accepted instructions, advances.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req && !prev_req) q_issue.push_back(imem_addr);
            if (instr_valid && instr_ready && !flush)
                q_acc.push_back('{instr: instr, pc: instr_pc, pc4: instr_pc_plus_4});
            if (pc_advance) adv_cnt++;
        end
        prev_req = imem_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        pc_init     = pc0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        redirect    = 32'd0;
        instr_ready = 1'b0;
        lat         = 0;
        step();
        step();
        q_acc.delete();
        q_issue.delete();
        adv_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=%0t exp=finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        adv_cnt  = 0;
        prev_req = 1'b0;

        // Reset values, minimum latency and a sequential zero-wait stream.
        do_reset(32'd0);
        check("rst_req",        imem_req,        32'd0);
        check("rst_addr",       imem_addr,       32'd0);
        check("rst_valid",      instr_valid,     32'd0);
        check("rst_instr",      instr,           32'd0);
        check("rst_instr_pc",   instr_pc,        32'd0);
        check("rst_instr_pc4",  instr_pc_plus_4, 32'd0);
        check("rst_advance",    pc_advance,      32'd0);
        instr_ready = 1'b1;
        rst_n       = 1'b1;
        step();
        check("a_c1_req",       imem_req,        32'd1);
        check("a_c1_addr",      imem_addr,       32'h0);
        check("a_c1_advance",   pc_advance,      32'd1);
        check("a_c1_valid",     instr_valid,     32'd0);
        step();
        check("a_c2_valid",     instr_valid,     32'd1);
        check("a_c2_instr_pc",  instr_pc,        32'h0);
        check("a_c2_instr",     instr,           32'hC0DE_0000);
        check("a_c2_pc4",       instr_pc_plus_4, 32'h4);
        repeat (8) step();
        check("a_issue_n",      q_issue.size() >= 3, 32'd1);
        check("a_issue0",       q_issue[0],      32'h0);
        check("a_issue1",       q_issue[1],      32'h4);
        check("a_issue2",       q_issue[2],      32'h8);
        check("a_acc_n",        q_acc.size() >= 3, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("a_acc%0d_pc", i),    q_acc[i].pc,    32'(4 * i));
            check($sformatf("a_acc%0d_instr", i), q_acc[i].instr, {16'hC0DE, 16'(4 * i)});
            check($sformatf("a_acc%0d_pc4", i),   q_acc[i].pc4,   32'(4 * i + 4));
        end

        // Decode stalled, 2-cycle memory: buffer fills to two and issue stops.
        do_reset(32'd0);
        lat   = 2;
        rst_n = 1'b1;
        repeat (20) step();
        check("b_valid",        instr_valid,     32'd1);
        check("b_head_pc",      instr_pc,        32'h0);
        check("b_head_pc4",     instr_pc_plus_4, 32'h4);
        check("b_req_idle",     imem_req,        32'd0);
        check("b_adv_cnt",      adv_cnt,         32'd2);
        check("b_issue_n",      q_issue.size(),  32'd2);
        check("b_issue1",       q_issue[1],      32'h4);
        // One pop frees a slot, then push and pop coincide at count 1.
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        #1;
        check("b_pop_head_pc",  instr_pc,        32'h4);
        check("b_reissue_req",  imem_req,        32'd1);
        check("b_reissue_addr", imem_addr,       32'h8);
        for (int k = 0; k < 10 && !pc_advance; k++) step();
        check("b_ack_seen",     pc_advance,      32'd1);
        instr_ready = 1'b1;
        step();
        check("b_pp_valid",     instr_valid,     32'd1);
        check("b_pp_head_pc",   instr_pc,        32'h8);
        check("b_pp_instr",     instr,           32'hC0DE_0008);
        check("b_pp_pc4",       instr_pc_plus_4, 32'hC);
        step();
        check("b_pp_count1",    instr_valid,     32'd0);

        // Flush with a request outstanding, flushed again while draining.
        do_reset(32'd0);
        instr_ready = 1'b1;
        lat         = 3;
        rst_n       = 1'b1;
        step();
        flush    = 1'b1;
        redirect = 32'h40;
        #1;
        check("c_flush_adv",    pc_advance,      32'd0);
        step();
        check("c_drain_req",    imem_req,        32'd1);
        check("c_drain_addr",   imem_addr,       32'h0);
        step();
        flush = 1'b0;
        #1;
        check("c_drain2_req",   imem_req,        32'd1);
        check("c_drain2_addr",  imem_addr,       32'h0);
        step();
        check("c_stale_ack",    imem_ack,        32'd1);
        check("c_stale_adv",    pc_advance,      32'd0);
        repeat (10) step();
        check("c_issue0",       q_issue[0],      32'h0);
        check("c_issue1",       q_issue[1],      32'h40);
        check("c_acc_n",        q_acc.size() >= 1, 32'd1);
        check("c_acc0_pc",      q_acc[0].pc,     32'h40);
        check("c_acc0_instr",   q_acc[0].instr,  32'hC0DE_0040);

        // Flush landing in the same cycle as the ack.
        do_reset(32'd0);
        instr_ready = 1'b1;
        lat         = 1;
        rst_n       = 1'b1;
        step();
        step();
        flush    = 1'b1;
        redirect = 32'h80;
        #1;
        check("d_ack_present",  imem_ack,        32'd1);
        check("d_flush_adv",    pc_advance,      32'd0);
        step();
        flush = 1'b0;
        #1;
        check("d_valid_after",  instr_valid,     32'd0);
        check("d_req_after",    imem_req,        32'd0);
        step();
        check("d_redir_req",    imem_req,        32'd1);
        check("d_redir_addr",   imem_addr,       32'h80);

        // Full buffer holds in IDLE; flush empties it and redirects.
        do_reset(32'd0);
        rst_n = 1'b1;
        repeat (6) step();
        check("e_full_valid",   instr_valid,     32'd1);
        check("e_full_noreq",   imem_req,        32'd0);
        check("e_full_issues",  q_issue.size(),  32'd2);
        flush       = 1'b1;
        redirect    = 32'h100;
        instr_ready = 1'b1;
        #1;
        check("e_flush_adv",    pc_advance,      32'd0);
        step();
        flush       = 1'b0;
        instr_ready = 1'b0;
        #1;
        check("e_valid_after",  instr_valid,     32'd0);
        step();
        check("e_redir_addr",   imem_addr,       32'h100);

        // Asynchronous reset mid-transaction, restart from the new PC.
        do_reset(32'd0);
        rst_n = 1'b1;
        step();
        step();
        lat = 5;
        step();
        check("f_pre_valid",    instr_valid,     32'd1);
        check("f_pre_req",      imem_req,        32'd1);
        #2;
        pc_init = 32'h200;
        rst_n   = 1'b0;
        #1;
        check("f_async_req",    imem_req,        32'd0);
        check("f_async_valid",  instr_valid,     32'd0);
        check("f_async_pc",     instr_pc,        32'd0);
        check("f_async_adv",    pc_advance,      32'd0);
        step();
        step();
        lat   = 0;
        rst_n = 1'b1;
        step();
        check("f_restart_req",  imem_req,        32'd1);
        check("f_restart_addr", imem_addr,       32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
